// File: rtl/load_store_unit_pkg.sv
// Shared op-code constants, FSM state encoding and request decode helpers for
// the load/store unit.
package load_store_unit_pkg;

    localparam logic [3:0] LSU_LD_B  = 4'h0;
    localparam logic [3:0] LSU_LD_H  = 4'h1;
    localparam logic [3:0] LSU_LD_W  = 4'h2;
    localparam logic [3:0] LSU_LD_BU = 4'h3;
    localparam logic [3:0] LSU_LD_HU = 4'h4;
    localparam logic [3:0] LSU_ST_B  = 4'h8;
    localparam logic [3:0] LSU_ST_H  = 4'h9;
    localparam logic [3:0] LSU_ST_W  = 4'hA;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } lsu_state_e;

    function automatic logic op_supported(input logic [3:0] op);
        case (op)
            LSU_LD_B, LSU_LD_H, LSU_LD_W, LSU_LD_BU, LSU_LD_HU,
            LSU_ST_B, LSU_ST_H, LSU_ST_W: op_supported = 1'b1;
            default:                      op_supported = 1'b0;
        endcase
    endfunction

    // Unsupported ops are never reported as misaligned.
    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] addr);
        case (op)
            LSU_LD_H, LSU_LD_HU, LSU_ST_H: op_misaligned = addr[0];
            LSU_LD_W, LSU_ST_W:            op_misaligned = |addr;
            default:                       op_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data extraction: selects the addressed byte/halfword lane from the RAM
// word and sign- or zero-extends it to 32 bits.
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [3:0]  op,
    output logic [31:0] data
);

    logic [31:0] lane;

    always_comb begin
        lane = rdata >> {addr, 3'b000};
        case (op)
            LSU_LD_B:  data = {{24{lane[7]}}, lane[7:0]};
            LSU_LD_H:  data = {{16{lane[15]}}, lane[15:0]};
            LSU_LD_W:  data = lane;
            LSU_LD_BU: data = {24'h0, lane[7:0]};
            LSU_LD_HU: data = {16'h0, lane[15:0]};
            default:   data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store initiator: one access at a time, byte-lane store
// replication, alignment checking and latency-tolerant load return.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_tag,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_tag,
    output logic        resp_ale,
    output logic [31:0] resp_badv,
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam logic [1:0] LatCnt  = 2'(RD_LAT);
    localparam bit         LatZero = (RD_LAT == 0);

    lsu_state_e  state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  tag_q, tag_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] rdata_ext_q, rdata_ext_d;
    logic        ale_q, ale_d;
    logic [31:0] badv_q, badv_d;
    logic [31:0] ld_data;

    load_align u_load_align (
        .rdata (ram_rdata),
        .addr  (addr_q[1:0]),
        .op    (op_q),
        .data  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= 4'h0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            tag_q       <= 5'h0;
            cnt_q       <= 2'd0;
            rdata_ext_q <= 32'h0;
            ale_q       <= 1'b0;
            badv_q      <= 32'h0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tag_q       <= tag_d;
            cnt_q       <= cnt_d;
            rdata_ext_q <= rdata_ext_d;
            ale_q       <= ale_d;
            badv_q      <= badv_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tag_d       = tag_q;
        cnt_d       = cnt_q;
        rdata_ext_d = rdata_ext_q;
        ale_d       = ale_q;
        badv_d      = badv_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d        = req_op;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    tag_d       = req_tag;
                    cnt_d       = 2'd0;
                    rdata_ext_d = 32'h0;
                    ale_d       = op_misaligned(req_op, req_addr[1:0]);
                    badv_d      = ale_d ? req_addr : 32'h0;
                    // Faults and unsupported ops never touch the RAM.
                    if (ale_d || !op_supported(req_op)) begin
                        state_d = StResp;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (op_q[3]) begin
                    state_d = StResp;
                end else if (LatZero) begin
                    state_d     = StResp;
                    rdata_ext_d = ld_data;
                end else begin
                    state_d = StWait;
                    cnt_d   = 2'd1;
                end
            end
            StWait: begin
                if (cnt_q == LatCnt) begin
                    state_d     = StResp;
                    rdata_ext_d = ld_data;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
        resp_data  = rdata_ext_q;
        resp_tag   = tag_q;
        resp_ale   = ale_q;
        resp_badv  = badv_q;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = 32'h0;
        ram_sel    = 4'h0;
        ram_wdata  = 32'h0;
        if (state_q == StIssue || state_q == StWait) begin
            ram_en   = 1'b1;
            ram_addr = {addr_q[31:2], 2'b00};
            ram_sel  = 4'hF;
            if (state_q == StIssue && op_q[3]) begin
                ram_we = 1'b1;
                case (op_q)
                    LSU_ST_B: begin
                        ram_sel   = 4'b0001 << addr_q[1:0];
                        ram_wdata = {4{wdata_q[7:0]}};
                    end
                    LSU_ST_H: begin
                        ram_sel   = 4'b0011 << addr_q[1:0];
                        ram_wdata = {2{wdata_q[15:0]}};
                    end
                    default: begin
                        ram_sel   = 4'hF;
                        ram_wdata = wdata_q;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: two units (RAM read latency 1 and 0) share one request
// stream, each backed by its own small byte-enabled RAM model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_tag;
    logic        resp_ready;

    logic        req_ready1, resp_valid1, resp_ale1, ram_en1, ram_we1;
    logic [31:0] resp_data1, resp_badv1, ram_addr1, ram_wdata1, ram_rdata1;
    logic [4:0]  resp_tag1;
    logic [3:0]  ram_sel1;

    logic        req_ready0, resp_valid0, resp_ale0, ram_en0, ram_we0;
    logic [31:0] resp_data0, resp_badv0, ram_addr0, ram_wdata0, ram_rdata0;
    logic [4:0]  resp_tag0;
    logic [3:0]  ram_sel0;

    load_store_unit #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready1), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .resp_valid(resp_valid1), .resp_ready(resp_ready), .resp_data(resp_data1),
        .resp_tag(resp_tag1), .resp_ale(resp_ale1), .resp_badv(resp_badv1),
        .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_sel(ram_sel1),
        .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
    );

    load_store_unit #(.RD_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready0), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .resp_valid(resp_valid0), .resp_ready(resp_ready), .resp_data(resp_data0),
        .resp_tag(resp_tag0), .resp_ale(resp_ale0), .resp_badv(resp_badv0),
        .ram_en(ram_en0), .ram_we(ram_we0), .ram_addr(ram_addr0), .ram_sel(ram_sel0),
        .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem1 [0:255];
    logic [31:0] mem0 [0:255];
    int          en_cnt1, we_cnt1;
    logic [31:0] last_waddr1, last_wdata1;
    logic [3:0]  last_sel1;

    assign ram_rdata0 = mem0[ram_addr0[9:2]];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= 32'h0;
                mem0[i] <= 32'h0;
            end
            en_cnt1     <= 0;
            we_cnt1     <= 0;
            last_waddr1 <= 32'h0;
            last_wdata1 <= 32'h0;
            last_sel1   <= 4'h0;
            ram_rdata1  <= 32'h0;
        end else begin
            if (ram_en1) begin
                en_cnt1 <= en_cnt1 + 1;
                if (ram_we1) begin
                    we_cnt1     <= we_cnt1 + 1;
                    last_waddr1 <= ram_addr1;
                    last_wdata1 <= ram_wdata1;
                    last_sel1   <= ram_sel1;
                    for (int b = 0; b < 4; b++)
                        if (ram_sel1[b]) mem1[ram_addr1[9:2]][8*b +: 8] <= ram_wdata1[8*b +: 8];
                end else begin
                    ram_rdata1 <= mem1[ram_addr1[9:2]];
                end
            end
            if (ram_en0 && ram_we0)
                for (int b = 0; b < 4; b++)
                    if (ram_sel0[b]) mem0[ram_addr0[9:2]][8*b +: 8] <= ram_wdata0[8*b +: 8];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_idle1(input string pfx);
        chk({pfx, " req_ready"}, {31'h0, req_ready1}, 32'h1);
        chk({pfx, " resp_valid"}, {31'h0, resp_valid1}, 32'h0);
        chk({pfx, " resp_data"}, resp_data1, 32'h0);
        chk({pfx, " resp_tag"}, {27'h0, resp_tag1}, 32'h0);
        chk({pfx, " resp_ale"}, {31'h0, resp_ale1}, 32'h0);
        chk({pfx, " resp_badv"}, resp_badv1, 32'h0);
        chk({pfx, " ram_en_we"}, {30'h0, ram_en1, ram_we1}, 32'h0);
        chk({pfx, " ram_addr"}, ram_addr1, 32'h0);
        chk({pfx, " ram_sel"}, {28'h0, ram_sel1}, 32'h0);
        chk({pfx, " ram_wdata"}, ram_wdata1, 32'h0);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  tag;
        logic [31:0] data;
        logic        ale;
        logic [31:0] badv;
        int          lat1;
        int          lat0;
        int          en1;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] waddr;
        logic [31:0] ramwd;
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        int          lat1, lat0, e1, w1;
        logic [31:0] d1, d0, b1;
        logic        a1, a0;
        logic [4:0]  t1;
        string       p;
        p = $sformatf("v%0d", idx);
        lat1 = -1; lat0 = -1;
        d1 = 'x; d0 = 'x; b1 = 'x; a1 = 1'bx; a0 = 1'bx; t1 = 'x;
        @(negedge clk);
        chk({p, " req_ready"}, {30'h0, req_ready1, req_ready0}, 32'h3);
        e1 = en_cnt1;
        w1 = we_cnt1;
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_tag   = v.tag;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (lat1 < 0 && resp_valid1) begin
                lat1 = k; d1 = resp_data1; a1 = resp_ale1; b1 = resp_badv1; t1 = resp_tag1;
            end
            if (lat0 < 0 && resp_valid0) begin
                lat0 = k; d0 = resp_data0; a0 = resp_ale0;
            end
            if (lat1 >= 0 && lat0 >= 0) break;
            @(negedge clk);
        end
        chk({p, " lat1"}, lat1, v.lat1);
        chk({p, " lat0"}, lat0, v.lat0);
        chk({p, " data1"}, d1, v.data);
        chk({p, " data0"}, d0, v.data);
        chk({p, " ale1"}, {31'h0, a1}, {31'h0, v.ale});
        chk({p, " ale0"}, {31'h0, a0}, {31'h0, v.ale});
        chk({p, " badv1"}, b1, v.badv);
        chk({p, " tag1"}, {27'h0, t1}, {27'h0, v.tag});
        chk({p, " en_cycles"}, en_cnt1 - e1, v.en1);
        chk({p, " we_cycles"}, we_cnt1 - w1, {31'h0, v.we});
        if (v.we) begin
            chk({p, " ram_sel"}, {28'h0, last_sel1}, {28'h0, v.sel});
            chk({p, " ram_addr"}, last_waddr1, v.waddr);
            chk({p, " ram_wdata"}, last_wdata1, v.ramwd);
        end
    endtask

    vec_t vecs[$];

    initial begin
        int          e_snap, seen;
        logic [31:0] hold_data;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_op = 4'h0; req_addr = 32'h0; req_wdata = 32'h0; req_tag = 5'h0;
        resp_ready = 1'b1;

        // op addr wdata tag | data ale badv lat1 lat0 en1 we sel waddr ramwd
        vecs.push_back('{4'hA, 32'h100, 32'hDEADBEEF, 5'd1, 32'h0, 1'b0, 32'h0, 2, 2, 1, 1'b1,
                         4'hF, 32'h100, 32'hDEADBEEF});
        vecs.push_back('{4'h8, 32'h103, 32'h000000A5, 5'd2, 32'h0, 1'b0, 32'h0, 2, 2, 1, 1'b1,
                         4'h8, 32'h100, 32'hA5A5A5A5});
        vecs.push_back('{4'h0, 32'h103, 32'h0, 5'd3, 32'hFFFFFFA5, 1'b0, 32'h0, 3, 2, 2, 1'b0,
                         4'h0, 32'h0, 32'h0});
        vecs.push_back('{4'h3, 32'h103, 32'h0, 5'd4, 32'h000000A5, 1'b0, 32'h0, 3, 2, 2, 1'b0,
                         4'h0, 32'h0, 32'h0});
        vecs.push_back('{4'h9, 32'h202, 32'h00008001, 5'd5, 32'h0, 1'b0, 32'h0, 2, 2, 1, 1'b1,
                         4'hC, 32'h200, 32'h80018001});
        vecs.push_back('{4'h1, 32'h202, 32'h0, 5'd6, 32'hFFFF8001, 1'b0, 32'h0, 3, 2, 2, 1'b0,
                         4'h0, 32'h0, 32'h0});
        vecs.push_back('{4'h4, 32'h202, 32'h0, 5'd7, 32'h00008001, 1'b0, 32'h0, 3, 2, 2, 1'b0,
                         4'h0, 32'h0, 32'h0});
        vecs.push_back('{4'h2, 32'h100, 32'h0, 5'd8, 32'hA5ADBEEF, 1'b0, 32'h0, 3, 2, 2, 1'b0,
                         4'h0, 32'h0, 32'h0});
        vecs.push_back('{4'h2, 32'h105, 32'h0, 5'd9, 32'h0, 1'b1, 32'h105, 1, 1, 0, 1'b0,
                         4'h0, 32'h0, 32'h0});
        vecs.push_back('{4'h1, 32'h101, 32'h0, 5'd10, 32'h0, 1'b1, 32'h101, 1, 1, 0, 1'b0,
                         4'h0, 32'h0, 32'h0});
        vecs.push_back('{4'hA, 32'h102, 32'h12345678, 5'd11, 32'h0, 1'b1, 32'h102, 1, 1, 0, 1'b0,
                         4'h0, 32'h0, 32'h0});
        vecs.push_back('{4'h5, 32'h100, 32'hFFFFFFFF, 5'd12, 32'h0, 1'b0, 32'h0, 1, 1, 0, 1'b0,
                         4'h0, 32'h0, 32'h0});
        vecs.push_back('{4'hF, 32'h103, 32'h0, 5'd13, 32'h0, 1'b0, 32'h0, 1, 1, 0, 1'b0,
                         4'h0, 32'h0, 32'h0});
        vecs.push_back('{4'h0, 32'h101, 32'h0, 5'd14, 32'hFFFFFFBE, 1'b0, 32'h0, 3, 2, 2, 1'b0,
                         4'h0, 32'h0, 32'h0});
        vecs.push_back('{4'h1, 32'h100, 32'h0, 5'd15, 32'hFFFFBEEF, 1'b0, 32'h0, 3, 2, 2, 1'b0,
                         4'h0, 32'h0, 32'h0});
        vecs.push_back('{4'h9, 32'h200, 32'h00001234, 5'd16, 32'h0, 1'b0, 32'h0, 2, 2, 1, 1'b1,
                         4'h3, 32'h200, 32'h12341234});
        vecs.push_back('{4'h2, 32'h200, 32'h0, 5'd17, 32'h80011234, 1'b0, 32'h0, 3, 2, 2, 1'b0,
                         4'h0, 32'h0, 32'h0});
        vecs.push_back('{4'h4, 32'h200, 32'h0, 5'd31, 32'h00001234, 1'b0, 32'h0, 3, 2, 2, 1'b0,
                         4'h0, 32'h0, 32'h0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle1("reset");
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Back-pressured load: response must hold steady with no extra RAM traffic.
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid = 1'b1; req_op = 4'h2; req_addr = 32'h100; req_tag = 5'd21;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 10 && !resp_valid1; k++) @(negedge clk);
        chk("hold valid_first", {31'h0, resp_valid1}, 32'h1);
        e_snap = en_cnt1;
        hold_data = 32'hA5ADBEEF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d valid", k), {31'h0, resp_valid1}, 32'h1);
            chk($sformatf("hold%0d data", k), resp_data1, hold_data);
            chk($sformatf("hold%0d tag", k), {27'h0, resp_tag1}, 32'd21);
            chk($sformatf("hold%0d req_ready", k), {31'h0, req_ready1}, 32'h0);
        end
        chk("hold en_cycles", en_cnt1 - e_snap, 32'h0);
        resp_ready = 1'b1;
        @(negedge clk);
        chk("hold release valid", {31'h0, resp_valid1}, 32'h0);
        chk("hold release req_ready", {31'h0, req_ready1}, 32'h1);

        // Reset while the latency-1 unit sits in WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'h2; req_addr = 32'h100; req_tag = 5'd20;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("midrst ram_en_in_wait", {31'h0, ram_en1}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_idle1("midrst");
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid1) seen++;
        end
        chk("midrst no_resp", seen, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
